// File: rtl/bnn_cfg_pkg.sv
// Shared definitions for the BNN configuration loader: header field layout,
// message types, FSM state encoding and counter width.
package bnn_cfg_pkg;

  localparam int unsigned CFG_CNT_W     = 16;
  localparam int unsigned HDR_TYPE_LSB  = 0;
  localparam int unsigned HDR_TYPE_MSB  = 1;
  localparam int unsigned HDR_LAYER_LSB = 8;
  localparam int unsigned HDR_LAYER_MSB = 15;
  localparam int unsigned HDR_LAYER_W   = HDR_LAYER_MSB - HDR_LAYER_LSB + 1;
  localparam int unsigned HDR_CNT_LSB   = 16;
  localparam int unsigned HDR_CNT_MSB   = 31;

  typedef enum logic [1:0] {
    WEIGHTS = 2'd0,
    THRESH  = 2'd1,
    CLEAR   = 2'd2,
    RSVD    = 2'd3
  } cfg_type_e;

  typedef logic [1:0] cfg_state_e;
  localparam cfg_state_e ST_HDR  = 2'd0;
  localparam cfg_state_e ST_WGT  = 2'd1;
  localparam cfg_state_e ST_THR  = 2'd2;
  localparam cfg_state_e ST_SKIP = 2'd3;

endpackage

// File: rtl/bnn_cfg_loader.sv
// Configuration sequencer: turns a header/payload beat stream into per-layer
// one-hot weight/threshold write strobes and tracks which layers are loaded.
module bnn_cfg_loader
  import bnn_cfg_pkg::*;
#(
  parameter int unsigned LAYERS               = 8,
  parameter int unsigned MAX_PARALLEL_INPUTS  = 4,
  parameter int unsigned THRESHOLD_DATA_WIDTH = 32,
  parameter int unsigned CFG_DATA_WIDTH       = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CFG_DATA_WIDTH-1:0]       cfg_data,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic                            bnn_busy,
  output logic [MAX_PARALLEL_INPUTS-1:0]  weight_wr_data,
  output logic [LAYERS-1:0]               weight_wr_en,
  output logic [THRESHOLD_DATA_WIDTH-1:0] threshold_wr_data,
  output logic [LAYERS-1:0]               threshold_wr_en,
  output logic                            cfg_done,
  output logic                            cfg_err
);

  if (CFG_DATA_WIDTH < 32 || CFG_DATA_WIDTH < THRESHOLD_DATA_WIDTH ||
      CFG_DATA_WIDTH < MAX_PARALLEL_INPUTS) begin : g_bad_width
    $error("bnn_cfg_loader: CFG_DATA_WIDTH too narrow for header or write data");
  end

  cfg_state_e                      state, state_d;
  logic [CFG_CNT_W-1:0]            remaining, remaining_d;
  logic [HDR_LAYER_W-1:0]          layer, layer_d;
  logic [LAYERS-1:0]               wgt_loaded, wgt_loaded_d;
  logic [LAYERS-1:0]               thr_loaded, thr_loaded_d;
  logic                            ready_d, done_d, err_d;
  logic [LAYERS-1:0]               weight_wr_en_d, threshold_wr_en_d;
  logic [MAX_PARALLEL_INPUTS-1:0]  weight_wr_data_d;
  logic [THRESHOLD_DATA_WIDTH-1:0] threshold_wr_data_d;

  cfg_type_e              hdr_type;
  logic [HDR_LAYER_W-1:0] hdr_layer;
  logic [CFG_CNT_W-1:0]   hdr_cnt;
  logic                   layer_ok;
  logic [LAYERS-1:0]      layer_oh;
  logic                   fire;
  logic                   unused_cfg;

  assign hdr_type   = cfg_type_e'(cfg_data[HDR_TYPE_MSB:HDR_TYPE_LSB]);
  assign hdr_layer  = cfg_data[HDR_LAYER_MSB:HDR_LAYER_LSB];
  assign hdr_cnt    = cfg_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign layer_ok   = 32'(hdr_layer) < LAYERS;
  assign layer_oh   = LAYERS'(1) << layer;
  assign fire       = cfg_valid && cfg_ready;
  assign unused_cfg = ^cfg_data;

  // Next-state, counters, bitmaps and registered outputs
  always_comb begin
    state_d             = state;
    remaining_d         = remaining;
    layer_d             = layer;
    wgt_loaded_d        = wgt_loaded;
    thr_loaded_d        = thr_loaded;
    err_d               = cfg_err;
    weight_wr_en_d      = '0;
    threshold_wr_en_d   = '0;
    weight_wr_data_d    = weight_wr_data;
    threshold_wr_data_d = threshold_wr_data;

    case (state)
      ST_HDR: begin
        if (fire) begin
          case (hdr_type)
            WEIGHTS, THRESH: begin
              if (!layer_ok) begin
                err_d = 1'b1;
                if (hdr_cnt != '0) begin
                  state_d     = ST_SKIP;
                  remaining_d = hdr_cnt;
                end
              end else if (hdr_cnt != '0) begin
                layer_d     = hdr_layer;
                remaining_d = hdr_cnt;
                state_d     = (hdr_type == WEIGHTS) ? ST_WGT : ST_THR;
              end
            end
            CLEAR: begin
              wgt_loaded_d = '0;
              thr_loaded_d = '0;
            end
            default: begin
              err_d = 1'b1;
              if (hdr_cnt != '0) begin
                state_d     = ST_SKIP;
                remaining_d = hdr_cnt;
              end
            end
          endcase
        end
      end
      ST_WGT: begin
        if (fire) begin
          weight_wr_en_d   = layer_oh;
          weight_wr_data_d = cfg_data[MAX_PARALLEL_INPUTS-1:0];
          remaining_d      = remaining - CFG_CNT_W'(1);
          if (remaining == CFG_CNT_W'(1)) begin
            wgt_loaded_d = wgt_loaded | layer_oh;
            state_d      = ST_HDR;
          end
        end
      end
      ST_THR: begin
        if (fire) begin
          threshold_wr_en_d   = layer_oh;
          threshold_wr_data_d = cfg_data[THRESHOLD_DATA_WIDTH-1:0];
          remaining_d         = remaining - CFG_CNT_W'(1);
          if (remaining == CFG_CNT_W'(1)) begin
            thr_loaded_d = thr_loaded | layer_oh;
            state_d      = ST_HDR;
          end
        end
      end
      ST_SKIP: begin
        if (fire) begin
          remaining_d = remaining - CFG_CNT_W'(1);
          if (remaining == CFG_CNT_W'(1)) state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase

    // Payload states never back-pressure; only headers wait on the datapath
    ready_d = (state_d == ST_HDR) ? !bnn_busy : 1'b1;
    done_d  = (&wgt_loaded_d) && (&thr_loaded_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_HDR;
      remaining         <= '0;
      layer             <= '0;
      wgt_loaded        <= '0;
      thr_loaded        <= '0;
      cfg_ready         <= 1'b0;
      cfg_done          <= 1'b0;
      cfg_err           <= 1'b0;
      weight_wr_en      <= '0;
      threshold_wr_en   <= '0;
      weight_wr_data    <= '0;
      threshold_wr_data <= '0;
    end else begin
      state             <= state_d;
      remaining         <= remaining_d;
      layer             <= layer_d;
      wgt_loaded        <= wgt_loaded_d;
      thr_loaded        <= thr_loaded_d;
      cfg_ready         <= ready_d;
      cfg_done          <= done_d;
      cfg_err           <= err_d;
      weight_wr_en      <= weight_wr_en_d;
      threshold_wr_en   <= threshold_wr_en_d;
      weight_wr_data    <= weight_wr_data_d;
      threshold_wr_data <= threshold_wr_data_d;
    end
  end

endmodule

// File: doc/bnn_cfg_loader.md
# bnn_cfg_loader

Configuration sequencer for the BNN datapath. It consumes a valid/ready configuration stream of header and payload beats, decodes each message's type and target layer, and issues the per-layer one-hot weight and threshold write strobes with their write data. It tracks which layers have been fully loaded and raises `cfg_done` once the network is ready for inference. It sits between the host or DMA configuration port and the `bnn` top's `weight_wr_*` and `threshold_wr_*` inputs.

## Interface
- `LAYERS`, default 8: number of layers; width of the write-enable and loaded bitmaps.
- `MAX_PARALLEL_INPUTS`, default 4: weight write-data width.
- `THRESHOLD_DATA_WIDTH`, default 32: threshold write-data width.
- `CFG_DATA_WIDTH`, default 64: stream width. Must be ≥ 32, ≥ `THRESHOLD_DATA_WIDTH` and ≥ `MAX_PARALLEL_INPUTS`; this is checked by an elaboration assertion.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_data`  in  `CFG_DATA_WIDTH`  stream beat.
- `cfg_valid`  in  1  beat valid.
- `cfg_ready`  out  1  beat accepted when `cfg_valid && cfg_ready`.
- `bnn_busy`  in  1  datapath is inferring; headers are not accepted while it is high.
- `weight_wr_data`  out  `MAX_PARALLEL_INPUTS`  weight word.
- `weight_wr_en`  out  `LAYERS`  one-hot weight strobe.
- `threshold_wr_data`  out  `THRESHOLD_DATA_WIDTH`  threshold word.
- `threshold_wr_en`  out  `LAYERS`  one-hot threshold strobe.
- `cfg_done`  out  1  every layer has both weights and thresholds loaded.
- `cfg_err`  out  1  sticky: a malformed header was seen.

## Operation
- Header fields:
  - `[1:0]` type: 0 = WEIGHTS, 1 = THRESH, 2 = CLEAR, 3 = reserved.
  - `[15:8]` layer id.
  - `[31:16]` beat count N, unsigned.
  - All other header bits are ignored.
- FSM states are HDR, WGT, THR and SKIP. All reset to HDR.
- HDR:
  - `cfg_ready = !bnn_busy`.
  - On an accepted header:
    - WEIGHTS or THRESH with a valid layer (< `LAYERS`) and N > 0: latch the layer and load `remaining` = N. Go to WGT or THR.
    - WEIGHTS or THRESH with N = 0: no writes, no change to the loaded bitmaps, stay in HDR.
    - CLEAR: zero `wgt_loaded` and `thr_loaded`, stay in HDR. Its layer and N fields are ignored.
    - Layer ≥ `LAYERS` or type 3: set `cfg_err`. If N > 0 go to SKIP with `remaining` = N; otherwise stay in HDR.
- WGT and THR:
  - `cfg_ready = 1`, independent of `bnn_busy`.
  - Each accepted beat issues one write: the low bits of the beat become the write data, and only the latched layer's enable bit is asserted.
  - Each accepted beat decrements `remaining`. On the beat where `remaining` = 1, set the layer's bit in `wgt_loaded` or `thr_loaded` and return to HDR.
- SKIP:
  - `cfg_ready = 1`.
  - Beats are consumed with no writes.
  - On the beat where `remaining` = 1, return to HDR.
- Output rules:
  - `cfg_done = &wgt_loaded && &thr_loaded`, registered.
  - Reloading a layer that is already loaded is legal; its bit stays set.
  - `cfg_err` is cleared only by reset.
- Write addressing inside a layer is implicit and sequential. The datapath owns its own address counters. This block asserts exactly N strobes per message.

## Timing
- Reset values:
  - `cfg_ready` = 0 while `rst_n` is low, then follows the HDR rule.
  - `weight_wr_en`, `threshold_wr_en`, both write-data buses, `cfg_done`, `cfg_err`, the bitmaps and `remaining` are all 0.
- Strobes and write data are registered. A payload beat accepted at edge k produces its `*_wr_en` and data for exactly the cycle after edge k. Enables drop the following cycle unless another beat was accepted.
- Throughput is one beat per cycle with no bubbles inside a message. The first payload beat can be accepted the cycle after the header is accepted.
- `cfg_ready` is a registered function of state and `bnn_busy` only, so it has no combinational path from `cfg_valid`.
- `cfg_done` and the bitmaps update on the edge that completes the final beat. `cfg_done` is therefore visible in the same cycle as the final strobe.
- `cfg_valid` low in mid-message stalls with state held; no strobe is issued.
- `bnn_busy` rising in mid-message does not stall the message. It only blocks the next header.
- Asserting `rst_n` low in mid-message immediately clears the strobes and state. A partially written layer is not marked as loaded.
- N = 65535 is legal. `remaining` is 16 bits and never wraps.

## Structure
- Package `bnn_cfg_pkg` holds:
  - `cfg_type_e` (WEIGHTS, THRESH, CLEAR, RSVD);
  - `cfg_state_e`;
  - the header field bit-position localparams;
  - `CFG_CNT_W` = 16.
- The block is one flat module. The state machine and the bitmap register file are small enough not to need a sub-module.

## Test plan
- LAYERS=8. Send WEIGHTS layer 2 N=3, beats 0x1, 0x2, 0x3 back-to-back → `weight_wr_en` = 8'b00000100 for 3 consecutive cycles with data 1, 2, 3; no threshold strobe; `wgt_loaded` = 8'h04.
- Load weights and thresholds for all 8 layers → `cfg_done` rises on the cycle of the last strobe. Then send CLEAR → `cfg_done` = 0 the next cycle.
- Send a header with layer 9, N=2, followed by 2 beats → no strobes, `cfg_err` = 1. The next valid THRESH layer 0 N=1 writes normally.
- Hold `bnn_busy` = 1 with a header pending → `cfg_ready` = 0 and nothing is consumed. Drop `bnn_busy` → header accepted.
- Start THRESH layer 5 N=4, toggle `cfg_valid` low for 3 cycles between beats → exactly 4 strobes, no gaps mis-counted. Assert reset after 2 beats instead → strobes 0 immediately, `thr_loaded` = 0.
- WEIGHTS N=0 → `cfg_ready` stays 1, no strobes, bitmaps unchanged.
